result_writeback_unit: RTL
==========================

# result_writeback_unit

Drains finished output rows from the accumulator array and writes them, requantized to 8-bit, into the unified buffer. It is the write-side counterpart of the unified-buffer/accumulator read path: the control unit reads activations out of the unified buffer, and this block writes results back in. It starts on the control unit's `done_o` pulse and runs one row per cycle when the unified buffer write port is not stalled.

## Interface
- `MUL_SIZE`, 16: number of lanes per row. Equal to the systolic array dimension.
- `ACC_W`, 32: width of each signed accumulator lane.
- `ACC_AW`, 10: accumulator address width.
- `UB_AW`, 12: unified buffer address width.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle pulse that begins a drain; sampled only in IDLE.
- `rows_i`  in  7  number of rows to drain; 0 is legal.
- `accum_base_i`  in  ACC_AW  first accumulator row to read.
- `ub_base_i`  in  UB_AW  first unified buffer row to write.
- `shift_i`  in  5  arithmetic right-shift amount used for requantization.
- `acc_rd_en_o`  out  1  accumulator read strobe.
- `acc_addr_rd_o`  out  ACC_AW  accumulator read address.
- `acc_rdata_i`  in  MUL_SIZE*ACC_W  read data; valid exactly 1 cycle after `acc_rd_en_o`.
- `ub_wr_en_o`  out  1  write valid to the unified buffer.
- `ub_addr_wr_o`  out  UB_AW  unified buffer write address.
- `ub_data_o`  out  MUL_SIZE*8  requantized row data.
- `ub_wr_ready_i`  in  1  write accepted when high together with `ub_wr_en_o`.
- `busy_o`  out  1  high from the cycle after `start_i` until `done_o`, inclusive.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, DRAIN, FLUSH, DONE.
  - IDLE -> DRAIN when `start_i` is high and `rows_i` is nonzero.
  - IDLE -> DONE when `start_i` is high and `rows_i` is 0.
  - DRAIN -> FLUSH in the cycle the last read is issued.
  - FLUSH -> DONE when the last write is accepted.
  - DONE -> IDLE unconditionally.
- On start, latch `rows_i`, `accum_base_i`, `ub_base_i` and `shift_i`. Later changes to these inputs are ignored until the next drain.
- Reads:
  - Issued in DRAIN only while `outstanding + buffered < 2`, where `outstanding` counts reads whose data has not yet returned and `buffered` counts rows held in the output stage.
  - The read address increments by 1 per read and wraps modulo 2^ACC_AW.
- Output stage:
  - A 2-entry skid buffer. Head entry drives `ub_wr_en_o`, `ub_addr_wr_o` and `ub_data_o`.
  - Returned data is captured 1 cycle after its read and requantized before it enters the buffer.
  - The head entry pops when `ub_wr_en_o && ub_wr_ready_i`.
  - The write address increments by 1 per accepted write and wraps modulo 2^UB_AW.
- Requantization, per lane: arithmetic shift right by the latched shift, truncating (no rounding), then saturate to the signed 8-bit range [-128, 127].
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and ordering is preserved.
- `start_i` while busy is ignored.
- Reset mid-drain abandons the drain immediately: no `done_o` pulse, the FIFO is cleared, and the FSM returns to IDLE.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE.
- `start_i` high at cycle T:
  - `acc_rd_en_o` at T+1.
  - Data captured at T+2.
  - First `ub_wr_en_o` at T+3.
- With `ub_wr_ready_i` held high: one write per cycle, and the last write occurs at T+2+N.
- `done_o` asserts the cycle after the last accepted write.
- For `rows_i` = 0: `done_o` at T+1 and no reads or writes occur.
- While `ub_wr_ready_i` is low: `ub_wr_en_o`, `ub_addr_wr_o` and `ub_data_o` hold stable, and reads stop once 2 rows are in flight or buffered.
- Write valid is never withdrawn before it is accepted.

## Configuration
- Macro `WRITEBACK_RELU_EN`.
- Defined: each lane is clamped at 0 before the shift, so negative results write 0 and the output range is [0, 127].
- Undefined: signed saturation only, as described under Operation. Output range is [-128, 127].
- Latency is identical in both builds.

## Test plan
- `rows_i`=4, `accum_base_i`=0x3F0, `ub_base_i`=0x100, `shift_i`=0, `ub_wr_ready_i` held 1 -> writes to 0x100..0x103 on cycles T+3..T+6, `done_o` at T+7, 4 reads from 0x3F0..0x3F3.
- Lane values 1000, -1000, 255 with `shift_i`=2 -> 127, -128, 63. With `WRITEBACK_RELU_EN`: 127, 0, 63.
- `rows_i`=8 with `ub_wr_ready_i` toggling 1,0,0,1,... -> exactly 8 writes, in order, with no duplicated or dropped rows, at most 2 rows in flight, and outputs stable while stalled.
- `accum_base_i`=0x3FE, `ub_base_i`=0xFFF, `rows_i`=3 -> read addresses 0x3FE, 0x3FF, 0x000; write addresses 0xFFF, 0x000, 0x001.
- `rows_i`=0 -> `done_o` at T+1 with no `acc_rd_en_o` and no `ub_wr_en_o`. A second `start_i` during a busy drain is ignored.
- `rst_i` low at T+4 of a 6-row drain -> all outputs 0 next cycle with no `done_o`. A fresh start after reset release completes normally.

Source files
------------

// File: rtl/result_writeback_unit.sv
// Result writeback unit: drains accumulator rows, requantizes each lane to
// signed 8-bit and writes the rows into the unified buffer, one per cycle
// when the write port is not stalled.
// Optional build macro: WRITEBACK_RELU_EN clamps negative lanes to 0 before
// the shift, so the output range becomes [0, 127].
//
// state  | meaning
// IDLE   | waiting for start_i
// DRAIN  | issuing accumulator reads (at most 2 rows in flight or buffered)
// FLUSH  | all reads issued, emptying the output stage
// DONE   | one-cycle completion pulse
module result_writeback_unit #(
  parameter int MUL_SIZE = 16,
  parameter int ACC_W    = 32,
  parameter int ACC_AW   = 10,
  parameter int UB_AW    = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [6:0]                rows_i,
  input  logic [ACC_AW-1:0]         accum_base_i,
  input  logic [UB_AW-1:0]          ub_base_i,
  input  logic [4:0]                shift_i,
  output logic                      acc_rd_en_o,
  output logic [ACC_AW-1:0]         acc_addr_rd_o,
  input  logic [MUL_SIZE*ACC_W-1:0] acc_rdata_i,
  output logic                      ub_wr_en_o,
  output logic [UB_AW-1:0]          ub_addr_wr_o,
  output logic [MUL_SIZE*8-1:0]     ub_data_o,
  input  logic                      ub_wr_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [6:0]              rd_left_q, rd_left_d;
  logic [6:0]              wr_left_q, wr_left_d;
  logic [ACC_AW-1:0]       rd_addr_q, rd_addr_d;
  logic [UB_AW-1:0]        wr_addr_q, wr_addr_d;
  logic [4:0]              shift_q, shift_d;
  logic                    rd_en_q;
  logic [1:0]              cnt_q, cnt_d;
  logic [MUL_SIZE*8-1:0]   e0_q, e0_d, e1_q, e1_d;

  logic                    rd_en;
  logic                    pop;
  logic [2:0]              inflight;
  logic [MUL_SIZE*8-1:0]   cap_data;
  logic signed [ACC_W-1:0] lane_s, shifted_s;

  // Requantize the returning row: optional clamp at 0, arithmetic shift, saturate.
  always_comb begin
    cap_data  = '0;
    lane_s    = '0;
    shifted_s = '0;
    for (int i = 0; i < MUL_SIZE; i++) begin
      lane_s = $signed(acc_rdata_i[i*ACC_W +: ACC_W]);
`ifdef WRITEBACK_RELU_EN
      if (lane_s < 0) lane_s = '0;
`endif
      shifted_s = lane_s >>> shift_q;
      if (shifted_s > ACC_W'(127))
        cap_data[i*8 +: 8] = 8'h7F;
      else if (shifted_s < ACC_W'(-128))
        cap_data[i*8 +: 8] = 8'h80;
      else
        cap_data[i*8 +: 8] = shifted_s[7:0];
    end
  end

  // Next-state logic for the FSM, read issue and address/row counters.
  always_comb begin
    state_d   = state_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    shift_d   = shift_q;
    pop       = (cnt_q != 2'd0) && ub_wr_ready_i;
    // A row leaving this cycle frees its slot, so the read pipeline keeps full rate.
    inflight  = {2'b00, rd_en_q} + {1'b0, cnt_q} - {2'b00, pop};
    rd_en     = (state_q == S_DRAIN) && (inflight < 3'd2);
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_left_d = rows_i;
          wr_left_d = rows_i;
          rd_addr_d = accum_base_i;
          wr_addr_d = ub_base_i;
          shift_d   = shift_i;
          state_d   = (rows_i == 7'd0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_en) begin
          rd_left_d = rd_left_q - 7'd1;
          rd_addr_d = rd_addr_q + ACC_AW'(1);
          if (rd_left_q == 7'd1) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pop && (wr_left_q == 7'd1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      wr_left_d = wr_left_q - 7'd1;
      wr_addr_d = wr_addr_q + UB_AW'(1);
    end
  end

  // Two-entry skid buffer; entry 0 is the head presented to the unified buffer.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({rd_en_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = cap_data;
        else               e1_d = cap_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = cap_data;
        end else begin
          e0_d = e1_q;
          e1_d = cap_data;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset abandons any drain in progress.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      rd_left_q <= '0;
      wr_left_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      shift_q   <= '0;
      rd_en_q   <= 1'b0;
      cnt_q     <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      shift_q   <= shift_d;
      rd_en_q   <= rd_en;
      cnt_q     <= cnt_d;
      e0_q      <= e0_d;
      e1_q      <= e1_d;
    end
  end

  assign acc_rd_en_o   = rd_en;
  assign acc_addr_rd_o = rd_addr_q;
  assign ub_wr_en_o    = (cnt_q != 2'd0);
  assign ub_addr_wr_o  = wr_addr_q;
  assign ub_data_o     = e0_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule
